// File: rtl/reg_wb_arbiter_if.sv
// Writeback arbiter bundle: two writeback requesters, long-latency issue, scoreboard queries, regfile write port.
// slave modport faces the arbiter; master modport faces the pipeline/regfile side.
// rdy is the global enable carried with the bus so stalls travel with the handshake signals.
interface reg_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              rdy;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic [ADDR_W-1:0] q_addr1;
    logic [ADDR_W-1:0] q_addr2;
    logic              q_busy1;
    logic              q_busy2;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport slave (
        input  rdy,
        input  a_valid, a_addr, a_data,
        output a_ready,
        input  b_valid, b_addr, b_data,
        output b_ready,
        input  iss_valid, iss_rd,
        input  q_addr1, q_addr2,
        output q_busy1, q_busy2,
        output we, waddr, wdata
    );

    modport master (
        output rdy,
        output a_valid, a_addr, a_data,
        input  a_ready,
        output b_valid, b_addr, b_data,
        input  b_ready,
        output iss_valid, iss_rd,
        output q_addr1, q_addr2,
        input  q_busy1, q_busy2,
        input  we, waddr, wdata
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Arbitrates pipeline (A) and long-latency (B) writebacks onto one regfile write port; keeps a RAW busy scoreboard.
// Latency: handshake in cycle N drives we/waddr/wdata in N+1 for one cycle; busy clear visible in N+1.
// Backpressure: at most one ready per cycle, none while rdy is low or in reset; WB_RR_EN selects round-robin ties.
module reg_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic            clk,
    input  logic            rst,
    reg_wb_arbiter_if.slave bus
);

`ifdef WB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    // last_grant: 0 = A, 1 = B. Reset to A so B wins the first tie.
    logic              last_grant;
    logic [NREG-1:0]   busy;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              en;
    logic              a_win_tie;
    logic              a_hs;
    logic              b_hs;
    logic              iss_set;
    logic              q_busy1_c;
    logic              q_busy2_c;

    // Handshakes only when enabled and out of reset; A takes a tie only in round-robin after B was last served.
    assign en        = bus.rdy && !rst;
    assign a_win_tie = RR_EN && last_grant;
    assign a_hs      = en && bus.a_valid && (!bus.b_valid || a_win_tie);
    assign b_hs      = en && bus.b_valid && !(bus.a_valid && a_win_tie);
    assign iss_set   = bus.rdy && bus.iss_valid && (bus.iss_rd != '0);

    assign bus.a_ready = a_hs;
    assign bus.b_ready = b_hs;
    assign bus.we      = we_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;

    // Registered write slot: one pulse per handshake, writes to x0 are swallowed, address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (a_hs) begin
            we_q    <= (bus.a_addr != '0);
            waddr_q <= bus.a_addr;
            wdata_q <= bus.a_data;
        end else if (b_hs) begin
            we_q    <= (bus.b_addr != '0);
            waddr_q <= bus.b_addr;
            wdata_q <= bus.b_data;
        end else begin
            we_q    <= 1'b0;
        end
    end

    // Priority state follows every completed handshake; held across stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b0;
        end else if (a_hs) begin
            last_grant <= 1'b0;
        end else if (b_hs) begin
            last_grant <= 1'b1;
        end
    end

    // Scoreboard: issue sets, B writeback clears, set wins on a same-cycle collision; entry 0 never sets.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (iss_set && (bus.iss_rd == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (b_hs && (bus.b_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Query lookup; addresses beyond NREG and x0 read as not busy.
    always_comb begin
        q_busy1_c = 1'b0;
        q_busy2_c = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (bus.q_addr1 == ADDR_W'(i)) begin
                q_busy1_c = busy[i];
            end
            if (bus.q_addr2 == ADDR_W'(i)) begin
                q_busy2_c = busy[i];
            end
        end
    end

    assign bus.q_busy1 = !rst && q_busy1_c;
    assign bus.q_busy2 = !rst && q_busy2_c;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// Build with +define+WB_RR_EN to exercise the round-robin variant.
module tb_reg_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) wb();

    reg_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (wb)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          busy_m [32];
    bit          last_b_m;      // 1 when B completed the most recent handshake
    bit          exp_we;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Who should be granted given the current inputs and the model's history.
    function automatic void grant(output bit ga, output bit gb);
        ga = 1'b0;
        gb = 1'b0;
        if (!rst && wb.rdy) begin
            if (wb.a_valid && !wb.b_valid) ga = 1'b1;
            else if (!wb.a_valid && wb.b_valid) gb = 1'b1;
            else if (wb.a_valid && wb.b_valid) begin
`ifdef WB_RR_EN
                if (last_b_m) ga = 1'b1;
                else          gb = 1'b1;
`else
                gb = 1'b1;
`endif
            end
        end
    endfunction

    function automatic bit q_exp(input logic [AW-1:0] a);
        return !rst && (a != 0) && busy_m[a];
    endfunction

    // One clock: compare everything at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit ga, gb;
        @(negedge clk);
        grant(ga, gb);
        check("a_ready", wb.a_ready, ga);
        check("b_ready", wb.b_ready, gb);
        check("q_busy1", wb.q_busy1, q_exp(wb.q_addr1));
        check("q_busy2", wb.q_busy2, q_exp(wb.q_addr2));
        check("we", wb.we, exp_we);
        if (exp_we) begin
            check("waddr", wb.waddr, exp_waddr);
            check("wdata", wb.wdata, exp_wdata);
        end
        @(posedge clk);
        if (rst) begin
            exp_we    = 1'b0;
            exp_waddr = '0;
            exp_wdata = '0;
            last_b_m  = 1'b0;
            foreach (busy_m[i]) busy_m[i] = 1'b0;
        end else begin
            exp_we = 1'b0;
            if (ga) begin
                exp_we    = (wb.a_addr != 0);
                exp_waddr = wb.a_addr;
                exp_wdata = wb.a_data;
                last_b_m  = 1'b0;
            end
            if (gb) begin
                exp_we    = (wb.b_addr != 0);
                exp_waddr = wb.b_addr;
                exp_wdata = wb.b_data;
                busy_m[wb.b_addr] = 1'b0;
                last_b_m  = 1'b1;
            end
            if (wb.rdy && wb.iss_valid && wb.iss_rd != 0) busy_m[wb.iss_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        wb.rdy       = 1'b1;
        wb.a_valid   = 1'b0;
        wb.b_valid   = 1'b0;
        wb.iss_valid = 1'b0;
    endtask

    logic [AW-1:0] tie_seq [4];
    logic [AW-1:0] tie_exp [4];

    initial begin
        rst = 1'b1;
        idle();
        wb.a_addr = '0; wb.a_data = '0;
        wb.b_addr = '0; wb.b_data = '0;
        wb.iss_rd = '0; wb.q_addr1 = '0; wb.q_addr2 = '0;
        exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0; last_b_m = 1'b0;
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles with everything requesting
        wb.a_valid = 1'b1; wb.b_valid = 1'b1; wb.iss_valid = 1'b1;
        wb.iss_rd = 5'd3; wb.q_addr1 = 5'd3; wb.q_addr2 = 5'd3;
        wb.a_addr = 5'd1; wb.a_data = 32'h1111_1111;
        wb.b_addr = 5'd2; wb.b_data = 32'h2222_2222;
        cycle();
        cycle();
        check("rst_waddr", wb.waddr, 0);
        check("rst_wdata", wb.wdata, 0);

        // Tie: first grant after reset goes to B
        rst = 1'b0;
        wb.iss_valid = 1'b0;
`ifdef WB_RR_EN
        tie_exp[0] = 5'd2; tie_exp[1] = 5'd1; tie_exp[2] = 5'd2; tie_exp[3] = 5'd1;
`else
        tie_exp[0] = 5'd2; tie_exp[1] = 5'd2; tie_exp[2] = 5'd2; tie_exp[3] = 5'd2;
`endif
        for (int k = 0; k < 4; k++) begin
            cycle();
            tie_seq[k] = wb.waddr;
            check("tie_we", wb.we, 1);
            check("tie_waddr", tie_seq[k], tie_exp[k]);
        end

        // Single A write with a gap after it
        idle();
        cycle();
        wb.a_valid = 1'b1; wb.a_addr = 5'd5; wb.a_data = 32'hDEAD_BEEF;
        cycle();
        check("sw_we", wb.we, 1);
        check("sw_waddr", wb.waddr, 5);
        check("sw_wdata", wb.wdata, 32'hDEAD_BEEF);
        idle();
        cycle();
        check("sw_we_off", wb.we, 0);

        // Scoreboard set then B release
        wb.iss_valid = 1'b1; wb.iss_rd = 5'd7; wb.q_addr1 = 5'd7;
        cycle();
        wb.iss_valid = 1'b0;
        check("sb_set", wb.q_busy1, 1);
        wb.b_valid = 1'b1; wb.b_addr = 5'd7; wb.b_data = 32'h0000_0777;
        cycle();
        wb.b_valid = 1'b0;
        check("sb_clr", wb.q_busy1, 0);
        check("sb_we", wb.we, 1);
        check("sb_waddr", wb.waddr, 7);
        wb.iss_valid = 1'b1; wb.iss_rd = 5'd0; wb.q_addr1 = 5'd0;
        cycle();
        wb.iss_valid = 1'b0;
        check("sb_x0", wb.q_busy1, 0);

        // Set and clear of x9 in the same cycle: set wins
        wb.iss_valid = 1'b1; wb.iss_rd = 5'd9; wb.q_addr1 = 5'd9;
        cycle();
        wb.b_valid = 1'b1; wb.b_addr = 5'd9; wb.b_data = 32'h9999_0009;
        cycle();
        idle();
        check("sc_we", wb.we, 1);
        check("sc_waddr", wb.waddr, 9);
        check("sc_busy", wb.q_busy1, 1);
        cycle();

        // Stall: nothing granted, issue ignored, busy held
        wb.iss_valid = 1'b1; wb.iss_rd = 5'd4;
        cycle();
        wb.rdy = 1'b0; wb.a_valid = 1'b1; wb.b_valid = 1'b1;
        wb.iss_rd = 5'd6; wb.q_addr1 = 5'd4; wb.q_addr2 = 5'd6;
        cycle();
        check("st_we", wb.we, 0);
        check("st_held", wb.q_busy1, 1);
        check("st_noiss", wb.q_busy2, 0);

        // Accepted write to x0 produces no regfile write
        idle();
        wb.a_valid = 1'b1; wb.a_addr = 5'd0; wb.a_data = 32'hFFFF_FFFF;
        cycle();
        check("x0_we", wb.we, 0);

        // Randomized traffic, including occasional mid-operation reset and stalls
        for (int n = 0; n < 1500; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            wb.rdy       = ($urandom_range(0, 9) != 0);
            wb.a_valid   = ($urandom_range(0, 9) < 6);
            wb.b_valid   = ($urandom_range(0, 9) < 5);
            wb.iss_valid = ($urandom_range(0, 9) < 3);
            wb.a_addr    = AW'($urandom);
            wb.b_addr    = AW'($urandom_range(0, 7));
            wb.iss_rd    = AW'($urandom_range(0, 7));
            wb.q_addr1   = AW'($urandom_range(0, 7));
            wb.q_addr2   = AW'($urandom);
            wb.a_data    = $urandom;
            wb.b_data    = $urandom;
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
